// File: rtl/alu_flag_unit.sv
// alu_flag_unit: multi-cycle 32-bit add/subtract, 8 bits per cycle over four
// cycles, producing the result word S and the Z/V/N compare flags.
//   clk, reset (async, active-low)
//   start          : request, sampled only in IDLE
//   A, B, Sub, Sign: operands and mode, captured at an accepted start
//   busy           : operation in progress
//   done           : one-cycle pulse, S/Z/V/N valid
//   S, Z, V, N     : registered result and flags, held until the next completion
module alu_flag_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Sub,
  input  logic        Sign,
  output logic        busy,
  output logic        done,
  output logic [31:0] S,
  output logic        Z,
  output logic        V,
  output logic        N
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] bop_q, bop_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] s_q, s_d;
  logic        sign_q, sign_d;
  logic        carry_q, carry_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        n_q, n_d;
  logic        done_q, done_d;

  logic [4:0]  base;
  logic [8:0]  slice;
  logic [31:0] sum_next;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    bop_d    = bop_q;
    sum_d    = sum_q;
    s_d      = s_q;
    sign_d   = sign_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    done_d   = 1'b0;

    // Current 8-bit slice with its carry-out in bit 8.
    base     = {cnt_q, 3'b000};
    slice    = {1'b0, a_q[base +: 8]} + {1'b0, bop_q[base +: 8]} + {8'd0, carry_q};
    sum_next = sum_q;
    sum_next[base +: 8] = slice[7:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
          bop_d   = B ^ {32{Sub}};
          sign_d  = Sign;
          carry_d = Sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_next;
        carry_d = slice[8];
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          s_d     = sum_next;
          z_d     = (sum_next == '0);
          n_d     = sum_next[31];
          v_d     = sign_q ? ((a_q[31] == bop_q[31]) & (sum_next[31] != a_q[31]))
                           : slice[8];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      bop_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bop_q   <= bop_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign S    = s_q;
  assign Z    = z_q;
  assign V    = v_q;
  assign N    = n_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed testbench for alu_flag_unit.
module tb_alu_flag_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        sub_i;
  logic        sign_i;
  logic        busy;
  logic        done;
  logic [31:0] s_o;
  logic        z_o;
  logic        v_o;
  logic        n_o;

  int n_checks;
  int n_fail;

  alu_flag_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (a_i),
    .B     (b_i),
    .Sub   (sub_i),
    .Sign  (sign_i),
    .busy  (busy),
    .done  (done),
    .S     (s_o),
    .Z     (z_o),
    .V     (v_o),
    .N     (n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle, scramble the operands right after acceptance,
  // then wait (bounded) for done. lat counts cycles from acceptance to done,
  // bcyc counts sampled cycles with busy high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sign,
                        output int lat, output int bcyc);
    @(negedge clk);
    a_i = a; b_i = b; sub_i = sub; sign_i = sign; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i = ~a; b_i = ~b; sub_i = ~sub; sign_i = ~sign;
    lat  = 0;
    bcyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1 && done !== 1'b1) bcyc++;
    end
    if (lat >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL run_op_timeout: done not seen within %0d cycles", lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; sign_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, s_o, z_o, v_o, n_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b S=%h Z=%b V=%b N=%b, want all 0",
               busy, done, s_o, z_o, v_o, n_o);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed_sub;
    int lat, bcyc;
    run_op(32'd5, 32'd3, 1'b1, 1'b1, lat, bcyc);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL ssub_latency: got %0d want 4", lat); end
    n_checks++;
    if (bcyc !== 4) begin n_fail++; $display("FAIL ssub_busy_cycles: got %0d want 4", bcyc); end
    n_checks++;
    if ({s_o, z_o, v_o, n_o, busy} !== {32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ssub_result: got S=%h Z=%b V=%b N=%b busy=%b want S=00000002 Z=0 V=0 N=0 busy=0",
               s_o, z_o, v_o, n_o, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL ssub_done_width: got done=%b want 0", done); end
  endtask

  task automatic test_add_overflow;
    int lat, bcyc;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, lat, bcyc);
    n_checks++;
    if ({s_o, z_o, v_o, n_o} !== {32'h80000000, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sadd_ovf: got S=%h Z=%b V=%b N=%b want S=80000000 Z=0 V=1 N=1",
               s_o, z_o, v_o, n_o);
    end
  endtask

  task automatic test_unsigned_sub;
    int lat, bcyc;
    run_op(32'd3, 32'd5, 1'b1, 1'b0, lat, bcyc);
    n_checks++;
    if ({s_o, z_o, v_o, n_o} !== {32'hFFFFFFFE, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL usub_borrow: got S=%h Z=%b V=%b N=%b want S=fffffffe Z=0 V=0 N=1",
               s_o, z_o, v_o, n_o);
    end
    run_op(32'h12345678, 32'h12345678, 1'b1, 1'b0, lat, bcyc);
    n_checks++;
    if ({s_o, z_o, v_o, n_o} !== {32'h00000000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL usub_equal: got S=%h Z=%b V=%b N=%b want S=00000000 Z=1 V=1 N=0",
               s_o, z_o, v_o, n_o);
    end
    // Results must hold after done drops.
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, s_o, z_o, v_o, n_o} !== {1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL usub_hold: got done=%b S=%h Z=%b V=%b N=%b want done=0 S=00000000 Z=1 V=1 N=0",
               done, s_o, z_o, v_o, n_o);
    end
  endtask

  task automatic test_ignore_busy;
    int dones, overlap, first_done;
    dones = 0; overlap = 0; first_done = -1;
    @(negedge clk);
    a_i = 32'd10; b_i = 32'd4; sub_i = 1'b1; sign_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_i = 32'd1; b_i = 32'd1; sub_i = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = i;
        n_checks++;
        if ({s_o, z_o, v_o, n_o} !== {32'd6, 1'b0, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL busy_ignore_result: got S=%h Z=%b V=%b N=%b want S=00000006 Z=0 V=1 N=0",
                   s_o, z_o, v_o, n_o);
        end
      end
      if (busy === 1'b1 && done === 1'b1) overlap++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_ignore_count: got %0d done pulses want 1", dones); end
    n_checks++;
    if (first_done !== 5) begin n_fail++; $display("FAIL busy_ignore_timing: done at cycle %0d want 5", first_done); end
    n_checks++;
    if (overlap !== 0) begin n_fail++; $display("FAIL busy_done_overlap: got %0d cycles want 0", overlap); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pa [3], pb [3], es [3];
    logic        psub [3], psign [3], ez [3], ev [3], en [3];
    int          t_done [3];
    int          cyc, k;
    pa[0] = 32'd1;        pb[0] = 32'd2; psub[0] = 1'b0; psign[0] = 1'b0;
    es[0] = 32'd3;        ez[0] = 1'b0;  ev[0] = 1'b0;   en[0] = 1'b0;
    pa[1] = 32'h80000000; pb[1] = 32'd1; psub[1] = 1'b1; psign[1] = 1'b1;
    es[1] = 32'h7FFFFFFF; ez[1] = 1'b0;  ev[1] = 1'b1;   en[1] = 1'b0;
    pa[2] = 32'hFFFFFFFF; pb[2] = 32'd1; psub[2] = 1'b0; psign[2] = 1'b0;
    es[2] = 32'h00000000; ez[2] = 1'b1;  ev[2] = 1'b1;   en[2] = 1'b0;
    @(negedge clk);
    a_i = pa[0]; b_i = pb[0]; sub_i = psub[0]; sign_i = psign[0]; start = 1'b1;
    @(negedge clk);
    a_i = pa[1]; b_i = pb[1]; sub_i = psub[1]; sign_i = psign[1];
    cyc = 1; k = 0;
    while (k < 3 && cyc < 40) begin
      if (done === 1'b1) begin
        t_done[k] = cyc;
        n_checks++;
        if ({s_o, z_o, v_o, n_o} !== {es[k], ez[k], ev[k], en[k]}) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: got S=%h Z=%b V=%b N=%b want S=%h Z=%b V=%b N=%b",
                   k, s_o, z_o, v_o, n_o, es[k], ez[k], ev[k], en[k]);
        end
        if (k == 2) start = 1'b0;
        k++;
      end else if (k < 2 && busy === 1'b1 && cyc > t_done_prev(k, t_done)) begin
        a_i = pa[k + 1]; b_i = pb[k + 1]; sub_i = psub[k + 1]; sign_i = psign[k + 1];
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses want 3", k);
    end else begin
      n_checks++;
      if (t_done[1] - t_done[0] !== 5 || t_done[2] - t_done[1] !== 5) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d and %0d cycles want 5 and 5",
                 t_done[1] - t_done[0], t_done[2] - t_done[1]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
  endtask

  // Cycle of the previous done pulse (0 before the first), used to switch
  // operands only after the pending operation has been accepted.
  function automatic int t_done_prev(input int k, input int t_done [3]);
    return (k == 0) ? 0 : t_done[k - 1];
  endfunction

  task automatic test_reset_mid;
    int lat, bcyc, dones;
    @(negedge clk);
    a_i = 32'h11111111; b_i = 32'h22222222; sub_i = 1'b0; sign_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, s_o, z_o, v_o, n_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy=%b done=%b S=%h Z=%b V=%b N=%b want all 0",
               busy, done, s_o, z_o, v_o, n_o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", dones); end
    run_op(32'h11111111, 32'h22222222, 1'b0, 1'b0, lat, bcyc);
    n_checks++;
    if (lat !== 4 || {s_o, z_o, v_o, n_o} !== {32'h33333333, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got lat=%0d S=%h Z=%b V=%b N=%b want lat=4 S=33333333 Z=0 V=0 N=0",
               lat, s_o, z_o, v_o, n_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_signed_sub();
    test_add_overflow();
    test_unsigned_sub();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
